// File: rtl/pc_seq_unit.sv
// Program-counter unit for the fetch stage.
// Selects the next PC from sequential, branch, jump, call and return targets.
// A circular return-address stack (RAS) backs CALL/RET, with sticky overflow and underflow flags.
module pc_seq_unit #(
    parameter int unsigned       PC_W      = 8,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               stall,
    input  logic [2:0]                         op,
    input  logic                               cond,
    input  logic [PC_W-1:0]                    imm,
    input  logic [PC_W-1:0]                    base,
    input  logic                               clr_flags,
    output logic [PC_W-1:0]                    pc,
    output logic [PC_W-1:0]                    next_pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_overflow,
    output logic                               ras_underflow
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PC_W-1:0]  ras_d [RAS_DEPTH];

    logic [PC_W-1:0]  seq;
    logic [PC_W-1:0]  target;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             do_push;
    logic             do_pop;
    logic             underflow_evt;

    // Target selection; branch offset adds modulo 2^PC_W, so two's complement imm is already sign-extended
    always_comb begin
        seq           = pc_q + PC_W'(1);
        target        = seq;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        underflow_evt = 1'b0;
        top_inc       = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
        top_dec       = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);
        case (op)
            OP_BRANCH: if (cond) target = pc_q + imm;
            OP_JUMP:   target = base + imm;
            OP_CALL: begin
                target  = base + imm;
                do_push = 1'b1;
            end
            OP_RET: begin
                if (cnt_q != '0) begin
                    target = ras_q[top_q];
                    do_pop = 1'b1;
                end else begin
                    underflow_evt = 1'b1;
                end
            end
            default: ;
        endcase
        next_pc = stall ? pc_q : target;
    end

    // Next state for PC, stack pointer, count and sticky flags; stall freezes everything
    always_comb begin
        pc_d  = next_pc;
        cnt_d = cnt_q;
        top_d = top_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        ras_d = ras_q;
        if (!stall) begin
            // Clear first so a same-cycle event still sets its flag
            if (clr_flags) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (do_push) begin
                top_d        = top_inc;
                ras_d[top_inc] = seq;
                if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (do_pop) begin
                top_d = top_dec;
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (underflow_evt) unf_d = 1'b1;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage; contents are meaningless while the count is zero, so no reset
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign pc            = pc_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed vector table, then random traffic against a queue-based model.
module tb_pc_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] op = 3'd0;
    logic       cond = 1'b0;
    logic [7:0] imm = 8'd0;
    logic [7:0] base = 8'd0;
    logic       clr_flags = 1'b0;
    logic [7:0] pc;
    logic [7:0] next_pc;
    logic [2:0] ras_count;
    logic       ras_overflow;
    logic       ras_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_seq_unit #(.PC_W(8), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .cond(cond),
        .imm(imm), .base(base), .clr_flags(clr_flags),
        .pc(pc), .next_pc(next_pc), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    // Reference model: PC as an integer, RAS as a queue (oldest at front)
    int m_pc = 0;
    int m_stack[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    function automatic int model_target(input logic [2:0] o, input logic c,
                                        input logic [7:0] i, input logic [7:0] b);
        int seqv = (m_pc + 1) % 256;
        int off  = (i >= 8'd128) ? int'(i) - 256 : int'(i);
        case (o)
            3'd1: return c ? ((m_pc + off + 256) % 256) : seqv;
            3'd2, 3'd3: return (int'(b) + int'(i)) % 256;
            3'd4: return (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : seqv;
            default: return seqv;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic s, input logic [2:0] o, input logic c,
                              input logic [7:0] i, input logic [7:0] b, input logic cl);
        int tgt;
        if (!r) begin
            m_pc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!s) begin
            tgt = model_target(o, c, i, b);
            if (cl) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (o == 3'd3) begin
                m_stack.push_back((m_pc + 1) % 256);
                if (m_stack.size() > 4) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
            end else if (o == 3'd4) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else m_unf = 1;
            end
            m_pc = tgt;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, check next_pc combinationally, then check state after the edge
    task automatic step(input logic r, input logic s, input logic [2:0] o, input logic c,
                        input logic [7:0] i, input logic [7:0] b, input logic cl);
        int exp_next;
        @(negedge clk);
        rst_n = r; stall = s; op = o; cond = c; imm = i; base = b; clr_flags = cl;
        #1;
        if (r) begin
            exp_next = s ? m_pc : model_target(o, c, i, b);
            chk("next_pc", int'(next_pc), exp_next);
        end
        model_step(r, s, o, c, i, b, cl);
        @(posedge clk);
        #1;
        chk("pc", int'(pc), m_pc);
        chk("ras_count", int'(ras_count), m_stack.size());
        chk("ras_overflow", int'(ras_overflow), int'(m_ovf));
        chk("ras_underflow", int'(ras_underflow), int'(m_unf));
    endtask

    typedef struct {
        logic       r;
        logic       s;
        logic [2:0] o;
        logic       c;
        logic [7:0] i;
        logic [7:0] b;
        logic       cl;
        logic [7:0] e_pc;
        logic [2:0] e_cnt;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [2:0] o, input logic c,
                       input logic [7:0] i, input logic [7:0] b, input logic cl,
                       input logic [7:0] e_pc, input logic [2:0] e_cnt,
                       input logic e_ovf, input logic e_unf);
        vec_t v;
        v.r = r; v.s = s; v.o = o; v.c = c; v.i = i; v.b = b; v.cl = cl;
        v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
        vecs.push_back(v);
    endtask

    initial begin
        //   r  s  op   c  imm    base   clr  pc     cnt  ovf unf
        // reset and sequential fetch
        add(0, 0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        add(0, 0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        add(1, 0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h01, 3'd0, 0, 0);
        add(1, 0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h02, 3'd0, 0, 0);
        add(1, 0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h03, 3'd0, 0, 0);
        // branches and wrap
        add(1, 0, 3'd2, 0, 8'h00, 8'h05, 0, 8'h05, 3'd0, 0, 0);
        add(1, 0, 3'd1, 1, 8'hFE, 8'h00, 0, 8'h03, 3'd0, 0, 0);
        add(1, 0, 3'd2, 0, 8'h00, 8'h05, 0, 8'h05, 3'd0, 0, 0);
        add(1, 0, 3'd1, 0, 8'hFE, 8'h00, 0, 8'h06, 3'd0, 0, 0);
        add(1, 0, 3'd2, 0, 8'h00, 8'hFF, 0, 8'hFF, 3'd0, 0, 0);
        add(1, 0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        add(1, 0, 3'd2, 0, 8'h00, 8'h7F, 0, 8'h7F, 3'd0, 0, 0);
        add(1, 0, 3'd1, 1, 8'h01, 8'h00, 0, 8'h80, 3'd0, 0, 0);
        // jump with carry discarded, reserved op as NEXT
        add(1, 0, 3'd2, 0, 8'h20, 8'hF0, 0, 8'h10, 3'd0, 0, 0);
        add(1, 0, 3'd6, 1, 8'h55, 8'h66, 0, 8'h11, 3'd0, 0, 0);
        // nested calls to overflow, returns to underflow
        add(1, 0, 3'd2, 0, 8'h00, 8'h10, 0, 8'h10, 3'd0, 0, 0);
        add(1, 0, 3'd3, 0, 8'h00, 8'h20, 0, 8'h20, 3'd1, 0, 0);
        add(1, 0, 3'd3, 0, 8'h00, 8'h30, 0, 8'h30, 3'd2, 0, 0);
        add(1, 0, 3'd3, 0, 8'h00, 8'h40, 0, 8'h40, 3'd3, 0, 0);
        add(1, 0, 3'd3, 0, 8'h00, 8'h50, 0, 8'h50, 3'd4, 0, 0);
        add(1, 0, 3'd3, 0, 8'h00, 8'h60, 0, 8'h60, 3'd4, 1, 0);
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 0, 8'h51, 3'd3, 1, 0);
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 0, 8'h41, 3'd2, 1, 0);
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 0, 8'h31, 3'd1, 1, 0);
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 0, 8'h21, 3'd0, 1, 0);
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 0, 8'h22, 3'd0, 1, 1);
        add(1, 0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h23, 3'd0, 0, 0);
        // clear coinciding with an underflow: the event wins
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 1, 8'h24, 3'd0, 0, 1);
        add(1, 0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h25, 3'd0, 0, 0);
        // stall holds through CALL and RET, then release
        add(1, 0, 3'd3, 0, 8'h00, 8'h80, 0, 8'h80, 3'd1, 0, 0);
        add(1, 1, 3'd3, 0, 8'h00, 8'h90, 0, 8'h80, 3'd1, 0, 0);
        add(1, 1, 3'd3, 0, 8'h00, 8'h90, 0, 8'h80, 3'd1, 0, 0);
        add(1, 1, 3'd3, 0, 8'h00, 8'h90, 0, 8'h80, 3'd1, 0, 0);
        add(1, 1, 3'd4, 0, 8'h00, 8'h00, 0, 8'h80, 3'd1, 0, 0);
        add(1, 1, 3'd4, 0, 8'h00, 8'h00, 0, 8'h80, 3'd1, 0, 0);
        add(1, 1, 3'd4, 0, 8'h00, 8'h00, 0, 8'h80, 3'd1, 0, 0);
        add(1, 0, 3'd3, 0, 8'h00, 8'h90, 0, 8'h90, 3'd2, 0, 0);
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 0, 8'h81, 3'd1, 0, 0);
        // reset in the middle of a call chain
        add(1, 0, 3'd3, 0, 8'h00, 8'hA0, 0, 8'hA0, 3'd2, 0, 0);
        add(0, 0, 3'd3, 0, 8'h00, 8'hB0, 0, 8'h00, 3'd0, 0, 0);
        add(1, 0, 3'd4, 0, 8'h00, 8'h00, 0, 8'h01, 3'd0, 0, 1);
        // stall also freezes the sticky flags against clr_flags
        add(1, 1, 3'd0, 0, 8'h00, 8'h00, 1, 8'h01, 3'd0, 0, 1);

        foreach (vecs[k]) begin
            step(vecs[k].r, vecs[k].s, vecs[k].o, vecs[k].c, vecs[k].i, vecs[k].b, vecs[k].cl);
            chk($sformatf("vec%0d_pc", k), int'(pc), int'(vecs[k].e_pc));
            chk($sformatf("vec%0d_cnt", k), int'(ras_count), int'(vecs[k].e_cnt));
            chk($sformatf("vec%0d_ovf", k), int'(ras_overflow), int'(vecs[k].e_ovf));
            chk($sformatf("vec%0d_unf", k), int'(ras_underflow), int'(vecs[k].e_unf));
        end

        // Random traffic, weighted toward CALL/RET to exercise the stack boundaries
        for (int n = 0; n < 400; n++) begin
            logic       r_r, r_s, r_c, r_cl;
            logic [2:0] r_o;
            r_r  = ($urandom_range(0, 31) != 0);
            r_s  = ($urandom_range(0, 4) == 0);
            r_c  = 1'($urandom_range(0, 1));
            r_cl = ($urandom_range(0, 7) == 0);
            r_o  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(3, 4)) : 3'($urandom_range(0, 7));
            step(r_r, r_s, r_o, r_c, 8'($urandom), 8'($urandom), r_cl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
